// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU types (opcodes, multiply/divide sequencer states) and a
// magnitude helper used when signed operands are latched.
package cpu_pkg;
    localparam int WIDTH = 32;

    typedef enum logic [6:0] {
        DIV   = 7'd7,
        DIVU  = 7'd8,
        MFHI  = 7'd9,
        MFLO  = 7'd10,
        MTHI  = 7'd11,
        MTLO  = 7'd12,
        MULT  = 7'd13,
        MULTU = 7'd14
    } opcode_t;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    // Absolute value when s is set, raw value otherwise.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
        return (s && v[WIDTH-1]) ? -v : v;
    endfunction
endpackage

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: execute-stage <-> HI/LO unit bundle.
// master (CPU): drives start, op, a, b, flush; reads ready, busy, done, rdata, hi, lo.
// slave (unit): the reverse.
interface muldiv_sequencer_if;
    import cpu_pkg::*;
    logic             start;
    opcode_t          op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] rdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, flush, input ready, busy, done, rdata, hi, lo);
    modport slave  (input start, op, a, b, flush, output ready, busy, done, rdata, hi, lo);
endinterface

// File: rtl/muldiv_iter.sv
// muldiv_iter: 64-bit iterative shift-add multiply / restoring divide datapath.
// Ports: clk, rst_n (async low); load puts lo_init in the low half and clears
// the high half; step performs one iteration using opnd (multiplicand or
// divisor) selected by is_div; acc is the accumulator (HI:LO form).
module muldiv_iter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic        is_div,
    input  logic [31:0] lo_init,
    input  logic [31:0] opnd,
    output logic [63:0] acc
);
    logic [32:0] sum;
    logic [33:0] diff;

    // Carry of the upper-half add lands in bit 63 after the right shift.
    assign sum  = {1'b0, acc[63:32]} + {1'b0, opnd};
    // Shifted partial remainder needs 33 bits since it can reach 2*divisor.
    assign diff = {1'b0, acc[63:31]} - {2'b0, opnd};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (load)
            acc <= {32'b0, lo_init};
        else if (step)
            acc <= is_div ? (diff[33] ? {acc[62:0], 1'b0} : {diff[31:0], acc[30:0], 1'b1})
                          : (acc[0] ? {sum, acc[31:1]} : {1'b0, acc[63:1]});
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle MULT/MULTU/DIV/DIVU controller owning HI/LO.
// Ports: clk, rst_n (async low), bus (slave): start/op/a/b/flush requests,
// ready/busy handshake, done pulse, rdata for MFHI/MFLO, hi/lo trace.
module muldiv_sequencer
    import cpu_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    muldiv_sequencer_if.slave bus
);
    state_t      state;
    opcode_t     op_r;
    logic [5:0]  cnt;
    logic [31:0] a_r, b_r, hi_r, lo_r, q, r;
    logic        neg_q, neg_r, done_r;
    logic [63:0] acc, p;
    logic        is_md, sgn, accept, is_div_r, dbz;

    assign is_md    = bus.op inside {MULT, MULTU, DIV, DIVU};
    assign sgn      = bus.op == MULT || bus.op == DIV;
    // flush wins over a same-edge request.
    assign accept   = bus.start && state == IDLE && !bus.flush;
    assign is_div_r = op_r == DIV || op_r == DIVU;
    assign dbz      = is_div_r && b_r == '0;

    muldiv_iter u_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept && is_md),
        .step    (state == RUN),
        .is_div  (is_div_r),
        .lo_init (mag(bus.a, sgn)),
        .opnd    (b_r),
        .acc     (acc)
    );

    // Sign correction: neg_q flips the product / quotient, neg_r the remainder.
    assign p = neg_q ? -acc : acc;
    assign q = neg_q ? -acc[31:0] : acc[31:0];
    assign r = neg_r ? -acc[63:32] : acc[63:32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_r   <= MULTU;
            cnt    <= '0;
            a_r    <= '0;
            b_r    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (state != IDLE && bus.flush)
                state <= IDLE;
            else
                case (state)
                    IDLE: if (accept) begin
                        if (is_md) begin
                            op_r  <= bus.op;
                            a_r   <= bus.a;
                            b_r   <= mag(bus.b, sgn);
                            neg_q <= sgn && (bus.a[31] ^ bus.b[31]);
                            neg_r <= sgn && bus.a[31];
                            cnt   <= '0;
                            state <= RUN;
                        end else if (bus.op == MTHI)
                            hi_r <= bus.a;
                        else if (bus.op == MTLO)
                            lo_r <= bus.a;
                    end
                    RUN: begin
                        cnt <= cnt + 6'd1;
                        if (cnt == 6'd31) state <= FIX;
                    end
                    FIX: begin
                        hi_r   <= !is_div_r ? p[63:32] : dbz ? a_r : r;
                        lo_r   <= !is_div_r ? p[31:0] : dbz ? 32'hFFFF_FFFF : q;
                        done_r <= 1'b1;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
        end
    end

    assign bus.busy  = state != IDLE;
    assign bus.ready = state == IDLE;
    assign bus.done  = done_r;
    assign bus.hi    = hi_r;
    assign bus.lo    = lo_r;
    assign bus.rdata = bus.op == MFHI ? hi_r : bus.op == MFLO ? lo_r : '0;
endmodule
